// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definitions (package)
// Description : Shared types for the loader and the core it sequences.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions;

    localparam int c_ADDR_W = 8;
    localparam int c_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DUMP = 3'd3,
        FIN  = 3'd4
    } loader_state;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_BEQ   = 4'h9,
        OP_HALT  = 4'hF
    } op_code;

endpackage
`default_nettype wire

// File: rtl/mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_if
// Description : Load stream, data-memory port and dump stream of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_loader_if;
    import definitions::*;

    logic [c_DATA_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    logic                mem_own;
    logic [c_ADDR_W-1:0] mem_addr;
    logic                mem_we;
    logic [c_DATA_W-1:0] mem_wdata;
    logic [c_DATA_W-1:0] mem_rdata;

    logic [c_DATA_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        input  in_data, in_valid, mem_rdata, out_ready,
        output in_ready, mem_own, mem_addr, mem_we, mem_wdata, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, mem_rdata, out_ready,
        input  in_ready, mem_own, mem_addr, mem_we, mem_wdata, out_data, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Loads a byte stream into data memory, runs the core until
//               done/timeout, then streams a result window back out.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter logic [7:0]  LD_BASE   = 8'd0,
    parameter int          LD_LEN    = 256,
    parameter logic [7:0]  DUMP_BASE = 8'd128,
    parameter int          DUMP_LEN  = 64,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        core_done,
    output logic             core_reset,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic [15:0]      run_cycles,
    mem_loader_if.master     bus
);
    import definitions::*;

    localparam logic [8:0]  c_LD_LAST   = 9'(LD_LEN - 1);
    localparam logic [8:0]  c_DUMP_LAST = 9'(DUMP_LEN - 1);
    localparam logic [15:0] c_TO_LAST   = TIMEOUT - 16'd1;

    loader_state r_state;
    logic [8:0]  r_cnt;
    logic        r_core_reset;
    logic        r_mem_own;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_finished;
    logic        r_timed_out;
    logic [15:0] r_run_cycles;

    logic        w_ld_hs;
    logic        w_dump_hs;

    assign w_ld_hs   = r_in_ready && bus.in_valid;
    assign w_dump_hs = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_core_reset <= 1'b1;
            r_mem_own    <= 1'b1;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
            r_timed_out  <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    if (start) begin
                        r_state      <= LOAD;
                        r_cnt        <= '0;
                        r_run_cycles <= '0;
                        r_timed_out  <= 1'b0;
                        r_finished   <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_ld_hs) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (r_cnt == c_LD_LAST) begin
                            r_state      <= RUN;
                            r_in_ready   <= 1'b0;
                            r_core_reset <= 1'b0;
                            r_mem_own    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (r_run_cycles != 16'hFFFF) begin
                        r_run_cycles <= r_run_cycles + 16'd1;
                    end
                    // core_done takes priority, so a simultaneous timeout is not flagged
                    if (core_done || (r_run_cycles == c_TO_LAST)) begin
                        r_state      <= DUMP;
                        r_timed_out  <= !core_done;
                        r_cnt        <= '0;
                        r_core_reset <= 1'b1;
                        r_mem_own    <= 1'b1;
                        r_out_valid  <= 1'b1;
                    end
                end
                DUMP: begin
                    if (w_dump_hs) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (r_cnt == c_DUMP_LAST) begin
                            r_state     <= FIN;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_finished  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address is held by cnt, so out_data stays stable while the dump is stalled
    assign bus.mem_addr  = r_out_valid ? (DUMP_BASE + r_cnt[7:0]) : (LD_BASE + r_cnt[7:0]);
    assign bus.mem_we    = w_ld_hs;
    assign bus.mem_wdata = bus.in_data;
    assign bus.mem_own   = r_mem_own;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = bus.mem_rdata;

    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign finished   = r_finished;
    assign timed_out  = r_timed_out;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Self-checking bench for mem_loader with a memory/core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
    import definitions::*;

    localparam logic [7:0]  LD_BASE   = 8'hFE;
    localparam int          LD_LEN    = 4;
    localparam logic [7:0]  DUMP_BASE = 8'h80;
    localparam int          DUMP_LEN  = 3;
    localparam logic [15:0] TIMEOUT   = 16'd20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        core_done;
    logic        core_reset;
    logic        busy;
    logic        finished;
    logic        timed_out;
    logic [15:0] run_cycles;

    mem_loader_if bus();

    mem_loader #(
        .LD_BASE   (LD_BASE),
        .LD_LEN    (LD_LEN),
        .DUMP_BASE (DUMP_BASE),
        .DUMP_LEN  (DUMP_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_done  (core_done),
        .core_reset (core_reset),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .run_cycles (run_cycles),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Data memory shared by loader and core; ref_mem is what it should hold
    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] core_res [3];
    int         core_cyc = 0;
    bit         done_en = 1'b0;
    int         done_at = 0;
    int         checks = 0;
    int         failures = 0;

    assign core_done     = done_en && !core_reset && (core_cyc == done_at - 1);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (core_reset) core_cyc <= 0;
        else            core_cyc <= core_cyc + 1;
        if (bus.mem_own) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end else if (core_cyc < 3) begin
            mem[DUMP_BASE + 8'(core_cyc)] <= core_res[core_cyc[1:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setup_core(input bit en, input int at);
        done_en = en;
        done_at = at;
        for (int k = 0; k < 3; k++) begin
            core_res[k] = 8'($urandom);
            ref_mem[8'(DUMP_BASE + k)] = core_res[k];
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", bus.in_ready, 1);
        check("start_busy", busy, 1);
        check("start_finished", finished, 0);
        check("start_run_cycles", run_cycles, 0);
    endtask

    task automatic load_bytes(input bit gap, input int n);
        int i = 0;
        int cyc = 0;
        logic [7:0] b;
        while (i < n && cyc < 64) begin
            if (gap && (cyc % 2 == 1)) begin
                bus.in_valid = 1'b0;
                #1;
                check("ld_stall_we", bus.mem_we, 0);
                check("ld_stall_addr", bus.mem_addr, 32'(8'(LD_BASE + i)));
            end else begin
                b = 8'($urandom);
                bus.in_data  = b;
                bus.in_valid = 1'b1;
                #1;
                check("ld_we", bus.mem_we, 1);
                check("ld_addr", bus.mem_addr, 32'(8'(LD_BASE + i)));
                ref_mem[8'(LD_BASE + i)] = b;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("ld_budget", i, n);
    endtask

    task automatic check_run_entry();
        check("run_in_ready", bus.in_ready, 0);
        check("run_core_reset", core_reset, 0);
        check("run_mem_own", bus.mem_own, 0);
        check("run_busy", busy, 1);
    endtask

    task automatic check_mem();
        for (int k = -1; k <= LD_LEN; k++) begin
            check("mem_content", mem[8'(LD_BASE + k)], ref_mem[8'(LD_BASE + k)]);
        end
    endtask

    task automatic run_and_dump(input bit stall, input int exp_rc, input bit exp_to);
        int w = 0;
        logic [7:0] exp;
        while (!bus.out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("dump_reached", bus.out_valid, 1);
        check("dump_run_cycles", run_cycles, exp_rc);
        check("dump_timed_out", timed_out, exp_to);
        check("dump_core_reset", core_reset, 1);
        check("dump_mem_own", bus.mem_own, 1);
        for (int j = 0; j < DUMP_LEN; j++) begin
            exp = ref_mem[8'(DUMP_BASE + j)];
            check("dump_valid", bus.out_valid, 1);
            check("dump_data", bus.out_data, exp);
            check("dump_addr", bus.mem_addr, 32'(8'(DUMP_BASE + j)));
            check("dump_we", bus.mem_we, 0);
            if (stall && j == 1) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, exp);
                    check("stall_addr", bus.mem_addr, 32'(8'(DUMP_BASE + j)));
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("fin_finished", finished, 1);
        check("fin_busy", busy, 0);
        check("fin_out_valid", bus.out_valid, 0);
        check("fin_core_reset", core_reset, 1);
        check("fin_timed_out", timed_out, exp_to);
    endtask

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_core_reset", core_reset, 1);
        check("rst_mem_own", bus.mem_own, 1);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_run_cycles", run_cycles, 0);

        // Back-to-back load, core halts on its 10th run cycle
        setup_core(1'b1, 10);
        do_start();
        load_bytes(1'b0, LD_LEN);
        check_run_entry();
        check_mem();
        run_and_dump(1'b0, 10, 1'b0);

        // Gapped load, core never halts, stalled dump, restart from FIN
        setup_core(1'b0, 0);
        do_start();
        load_bytes(1'b1, LD_LEN);
        check_run_entry();
        check_mem();
        run_and_dump(1'b1, 20, 1'b1);

        // done and timeout coincide
        setup_core(1'b1, 20);
        do_start();
        load_bytes(1'b0, LD_LEN);
        check_run_entry();
        run_and_dump(1'b0, 20, 1'b0);

        // Reset mid-load
        setup_core(1'b0, 0);
        do_start();
        load_bytes(1'b0, 2);
        reset = 1'b0;
        #1;
        check("arst_ld_core_reset", core_reset, 1);
        check("arst_ld_in_ready", bus.in_ready, 0);
        check("arst_ld_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reload restarts at LD_BASE, then reset mid-run
        do_start();
        load_bytes(1'b0, LD_LEN);
        check_run_entry();
        check_mem();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_run_core_reset", core_reset, 1);
        check("arst_run_mem_own", bus.mem_own, 1);
        check("arst_run_in_ready", bus.in_ready, 0);
        check("arst_run_cycles", run_cycles, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_finished", finished, 0);
        check("idle_busy", busy, 0);

        // Full sequence after reset
        setup_core(1'b1, 10);
        do_start();
        load_bytes(1'b0, LD_LEN);
        check_run_entry();
        check_mem();
        run_and_dump(1'b0, 10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
